// File: rtl/wb_sram_2port_arbiter_if.sv
// Bus interfaces for the two-port SRAM arbiter: a classic Wishbone leg and a
// generic byte-enable SRAM port.

interface wb_if #(
    parameter int ADR_WIDTH  = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADR_WIDTH-1:0]    adr;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    ack;
    logic                    err;

    modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
endinterface

interface generic_sram_byte_en_if #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH/8-1:0]  byte_en;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     write_en;
    logic                     read_en;

    modport sram_client (output addr, byte_en, write_data, write_en, read_en, input read_data);
    modport sram        (input addr, byte_en, write_data, write_en, read_en, output read_data);
endinterface

// File: rtl/wb_sram_2port_arbiter.sv
// Two Wishbone masters sharing one byte-enable SRAM with 1-cycle read latency.
// One transaction in flight: IDLE -> ACCESS (SRAM strobe) -> RESP (ACK).

module wb_sram_2port_arbiter #(
    parameter int ADDRESS_WIDTH  = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic clk,
    input  logic rstn,
    wb_if.slave  wb_s0,
    wb_if.slave  wb_s1,
    generic_sram_byte_en_if.sram_client sram_m
);
    localparam int W = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q;
    logic   grant_q;
    logic   last_q;

    logic   req0_s;
    logic   req1_s;
    logic   reqg_s;
    logic   rego_s;
    logic   weg_s;
    logic   unused_s;

    // A tie goes to port 0 under fixed priority, otherwise to the port not served last.
    function automatic logic pick(input logic r0, input logic r1, input logic last);
        logic p;
        if (r0 && !r1) begin
            p = 1'b0;
        end else if (!r0 && r1) begin
            p = 1'b1;
        end else if (FIXED_PRIORITY != 0) begin
            p = 1'b0;
        end else begin
            p = ~last;
        end
        return p;
    endfunction

    assign req0_s = wb_s0.cyc & wb_s0.stb;
    assign req1_s = wb_s1.cyc & wb_s1.stb;

    // Steer the granted master onto the SRAM; strobes only fire in ACCESS.
    always_comb begin
        if (grant_q) begin
            reqg_s             = req1_s;
            rego_s             = req0_s;
            weg_s              = wb_s1.we;
            sram_m.addr        = wb_s1.adr[ADDRESS_WIDTH-1+W:W];
            sram_m.byte_en     = wb_s1.sel;
            sram_m.write_data  = wb_s1.dat_w;
        end else begin
            reqg_s             = req0_s;
            rego_s             = req1_s;
            weg_s              = wb_s0.we;
            sram_m.addr        = wb_s0.adr[ADDRESS_WIDTH-1+W:W];
            sram_m.byte_en     = wb_s0.sel;
            sram_m.write_data  = wb_s0.dat_w;
        end
    end

    assign sram_m.write_en = (state_q == ACCESS) & reqg_s & weg_s;
    assign sram_m.read_en  = (state_q == ACCESS) & reqg_s & ~weg_s;

    assign wb_s0.ack   = (state_q == RESP) & ~grant_q & req0_s;
    assign wb_s1.ack   = (state_q == RESP) &  grant_q & req1_s;
    assign wb_s0.err   = 1'b0;
    assign wb_s1.err   = 1'b0;
    assign wb_s0.dat_r = sram_m.read_data;
    assign wb_s1.dat_r = sram_m.read_data;

    assign unused_s = ^{wb_s0.adr, wb_s1.adr};

    // Transaction sequencer; RESP hands straight to the other port when it is waiting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_s || req1_s) begin
                        grant_q <= pick(req0_s, req1_s, last_q);
                        state_q <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (reqg_s) begin
                        state_q <= RESP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RESP: begin
                    last_q <= grant_q;
                    if (rego_s) begin
                        grant_q <= ~grant_q;
                        state_q <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_sram_2port_arbiter.sv
// Directed bench: round-robin instance checked every cycle against a
// transaction-level model, fixed-priority instance checked with literal values.

module tb_wb_sram_2port_arbiter;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    wb_if #(.ADR_WIDTH(32), .DATA_WIDTH(32)) s0 (), s1 (), f0 (), f1 ();
    generic_sram_byte_en_if #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32)) sm (), fm ();

    wb_sram_2port_arbiter #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .rstn(rstn), .wb_s0(s0), .wb_s1(s1), .sram_m(sm));
    wb_sram_2port_arbiter #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rstn(rstn), .wb_s0(f0), .wb_s1(f1), .sram_m(fm));

    // Master drive arrays: index 0/1 = round-robin ports, 2/3 = fixed-priority ports
    logic        m_cyc [4];
    logic        m_stb [4];
    logic        m_we  [4];
    logic [31:0] m_adr [4];
    logic [3:0]  m_sel [4];
    logic [31:0] m_dat [4];
    logic [3:0]  ack_v;

    assign s0.cyc = m_cyc[0]; assign s0.stb = m_stb[0]; assign s0.we = m_we[0];
    assign s0.adr = m_adr[0]; assign s0.sel = m_sel[0]; assign s0.dat_w = m_dat[0];
    assign s1.cyc = m_cyc[1]; assign s1.stb = m_stb[1]; assign s1.we = m_we[1];
    assign s1.adr = m_adr[1]; assign s1.sel = m_sel[1]; assign s1.dat_w = m_dat[1];
    assign f0.cyc = m_cyc[2]; assign f0.stb = m_stb[2]; assign f0.we = m_we[2];
    assign f0.adr = m_adr[2]; assign f0.sel = m_sel[2]; assign f0.dat_w = m_dat[2];
    assign f1.cyc = m_cyc[3]; assign f1.stb = m_stb[3]; assign f1.we = m_we[3];
    assign f1.adr = m_adr[3]; assign f1.sel = m_sel[3]; assign f1.dat_w = m_dat[3];
    assign ack_v  = {f1.ack, f0.ack, s1.ack, s0.ack};

    // SRAM macros with 1-cycle read latency
    logic [31:0] mem_rr [1024];
    logic [31:0] mem_fp [1024];
    always @(posedge clk) begin
        if (sm.write_en) begin
            for (int b = 0; b < 4; b++) if (sm.byte_en[b]) mem_rr[sm.addr][8*b +: 8] <= sm.write_data[8*b +: 8];
        end
        if (sm.read_en) sm.read_data <= mem_rr[sm.addr];
    end
    always @(posedge clk) begin
        if (fm.write_en) begin
            for (int b = 0; b < 4; b++) if (fm.byte_en[b]) mem_fp[fm.addr][8*b +: 8] <= fm.write_data[8*b +: 8];
        end
        if (fm.read_en) fm.read_data <= mem_fp[fm.addr];
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE0000 + i;
    endfunction

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdat(input int p);
        case (p)
            0: return s0.dat_r;
            1: return s1.dat_r;
            2: return f0.dat_r;
            default: return f1.dat_r;
        endcase
    endfunction

    // ---------------- transaction-level model of the round-robin instance ----------------
    logic [31:0] model_mem [1024];
    int          tr_active = 0;   // a transaction owns the SRAM
    int          tr_stage  = 0;   // 0: SRAM access cycle, 1: response cycle
    int          tr_port   = 0;
    int          served_last = 1;
    logic [31:0] tr_rdata;
    int          rq [2];
    int          e_ack [2];
    int          e_we, e_re, other;
    logic [31:0] e_addr;

    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            chk("rst_ack0", s0.ack, 32'd0);
            chk("rst_ack1", s1.ack, 32'd0);
            chk("rst_we", sm.write_en, 32'd0);
            chk("rst_re", sm.read_en, 32'd0);
            tr_active   = 0;
            served_last = 1;
        end else begin
            rq[0] = int'(m_cyc[0] & m_stb[0]);
            rq[1] = int'(m_cyc[1] & m_stb[1]);
            e_ack[0] = 0; e_ack[1] = 0; e_we = 0; e_re = 0;
            e_addr = (m_adr[tr_port] >> 2) & 32'h3FF;
            if (tr_active != 0 && tr_stage == 0 && rq[tr_port] != 0) begin
                if (m_we[tr_port]) begin
                    e_we = 1;
                    for (int b = 0; b < 4; b++)
                        if (m_sel[tr_port][b]) model_mem[e_addr][8*b +: 8] = m_dat[tr_port][8*b +: 8];
                end else begin
                    e_re = 1;
                    tr_rdata = model_mem[e_addr];
                end
            end
            if (tr_active != 0 && tr_stage == 1 && rq[tr_port] != 0) e_ack[tr_port] = 1;
            chk("mdl_ack0", s0.ack, e_ack[0]);
            chk("mdl_ack1", s1.ack, e_ack[1]);
            chk("mdl_we", sm.write_en, e_we);
            chk("mdl_re", sm.read_en, e_re);
            if (e_we != 0 || e_re != 0) chk("mdl_addr", sm.addr, e_addr);
            if (e_ack[tr_port] != 0 && !m_we[tr_port]) chk("mdl_rdata", rdat(tr_port), tr_rdata);
            // advance to the next cycle's transaction
            if (tr_active == 0) begin
                if (rq[0] != 0 || rq[1] != 0) begin
                    tr_active = 1; tr_stage = 0;
                    tr_port = (rq[0] != 0 && rq[1] != 0) ? 1 - served_last : (rq[1] != 0 ? 1 : 0);
                end
            end else if (tr_stage == 0) begin
                if (rq[tr_port] != 0) tr_stage = 1; else tr_active = 0;
            end else begin
                served_last = tr_port;
                other = 1 - tr_port;
                if (rq[other] != 0) begin
                    tr_port = other; tr_stage = 0;
                end else begin
                    tr_active = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int p, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        m_cyc[p] = 1'b1; m_stb[p] = 1'b1; m_we[p] = we;
        m_adr[p] = adr;  m_sel[p] = sel;  m_dat[p] = dat;
    endtask

    task automatic release_port(input int p);
        m_cyc[p] = 1'b0; m_stb[p] = 1'b0; m_we[p] = 1'b0;
    endtask

    // Returns at the negedge of the ACK cycle; lat counts edges after the IDLE sample.
    task automatic wait_ack(input int p, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack_v[p]) begin
                lat = i - 1;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++; n_fails++;
            $display("FAIL ack_timeout: port %0d got no ACK, expected one within 20 cycles", p);
        end
    endtask

    task automatic xfer(input int p, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        drive(p, we, adr, sel, dat);
        wait_ack(p, lat);
        rd = rdat(p);
        @(posedge clk); #1;
        release_port(p);
    endtask

    function automatic logic [31:0] sram_addr(input int b);
        return (b == 0) ? 32'(sm.addr) : 32'(fm.addr);
    endfunction

    function automatic logic [31:0] sram_re(input int b);
        return (b == 0) ? 32'(sm.read_en) : 32'(fm.read_en);
    endfunction

    // Both ports of an instance request reads from IDLE; first = port index expected to win.
    task automatic dual(input int b, input int first);
        int second;
        second = (first == b) ? b + 1 : b;
        @(posedge clk); #1;
        drive(b, 1'b0, 32'd7 << 2, 4'hF, 32'd0);
        drive(b + 1, 1'b0, 32'd9 << 2, 4'hF, 32'd0);
        @(negedge clk);
        chk("dual_idle_ack", 32'(ack_v[b +: 2]), 32'd0);
        @(negedge clk);
        chk("dual_first_addr", sram_addr(b), (first == b) ? 32'd7 : 32'd9);
        chk("dual_first_re", sram_re(b), 32'd1);
        @(negedge clk);
        chk("dual_first_ack", 32'(ack_v[first]), 32'd1);
        chk("dual_other_noack", 32'(ack_v[second]), 32'd0);
        chk("dual_first_data", rdat(first), init_word((first == b) ? 7 : 9));
        @(posedge clk); #1;
        release_port(first);
        @(negedge clk);
        chk("dual_second_addr", sram_addr(b), (first == b) ? 32'd9 : 32'd7);
        @(negedge clk);
        chk("dual_second_ack", 32'(ack_v[second]), 32'd1);
        chk("dual_second_data", rdat(second), init_word((first == b) ? 9 : 7));
        @(posedge clk); #1;
        release_port(second);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1; rstn = 1'b0;
        @(posedge clk); #1; rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion within 200us");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        int lat, cnt0, cnt1, prev_port, prev_cyc, cyc_n, first_port, n_acks;
        logic [31:0] adr0, adr1;
        for (int i = 0; i < 1024; i++) begin
            mem_rr[i] = init_word(i); mem_fp[i] = init_word(i); model_mem[i] = init_word(i);
        end
        for (int p = 0; p < 4; p++) begin
            release_port(p); m_adr[p] = 32'd0; m_sel[p] = 4'h0; m_dat[p] = 32'd0;
        end
        rstn = 1'b0;
        #12;
        chk("reset_ack0", s0.ack, 32'd0);
        chk("reset_we", sm.write_en, 32'd0);
        chk("reset_re", sm.read_en, 32'd0);
        chk("reset_err", {s0.err, s1.err, f0.err, f1.err}, 32'd0);
        @(posedge clk); #1; rstn = 1'b1;

        // single write then read on port 0
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_idle_we", sm.write_en, 32'd0);
        @(negedge clk);
        chk("t1_we", sm.write_en, 32'd1);
        chk("t1_addr", sm.addr, 32'd4);
        @(negedge clk);
        chk("t1_ack", s0.ack, 32'd1);
        chk("t1_we_1cyc", sm.write_en, 32'd0);
        @(posedge clk); #1;
        release_port(0);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'd0, rd, lat);
        chk("t1_rdata", rd, 32'hDEADBEEF);
        chk("t1_rlat", lat, 32'd2);

        // byte-enable merge on port 1, word 5
        xfer(1, 1'b1, 32'h14, 4'hF, 32'h11223344, rd, lat);
        xfer(1, 1'b1, 32'h14, 4'b0101, 32'hAABBCCDD, rd, lat);
        xfer(1, 1'b0, 32'h14, 4'hF, 32'd0, rd, lat);
        chk("be_merge", rd, 32'h11BB33DD);

        // round-robin tie after port 0 was served last: port 1 wins
        xfer(0, 1'b0, 32'h40, 4'hF, 32'd0, rd, lat);
        dual(0, 1);

        // continuous contention from reset
        reset_pulse();
        adr0 = 32'd100 << 2; adr1 = 32'd300 << 2;
        @(posedge clk); #1;
        drive(0, 1'b0, adr0, 4'hF, 32'd0);
        drive(1, 1'b0, adr1, 4'hF, 32'd0);
        cnt0 = 0; cnt1 = 0; prev_port = -1; prev_cyc = 0; first_port = -1; n_acks = 0;
        for (cyc_n = 0; cyc_n < 400 && n_acks < 100; cyc_n++) begin
            @(negedge clk);
            if (s0.ack || s1.ack) begin
                if (first_port < 0) first_port = s1.ack ? 1 : 0;
                if (prev_port >= 0) begin
                    chk("rr_alternate", s1.ack ? 32'd1 : 32'd0, prev_port == 0 ? 32'd1 : 32'd0);
                    chk("rr_spacing", cyc_n - prev_cyc, 32'd2);
                end
                prev_port = s1.ack ? 1 : 0; prev_cyc = cyc_n; n_acks++;
                if (s0.ack) cnt0++;
                if (s1.ack) cnt1++;
            end
            @(posedge clk); #1;
            if (prev_cyc == cyc_n && prev_port == 0 && n_acks > 0) begin adr0 += 32'd4; m_adr[0] = adr0; end
            if (prev_cyc == cyc_n && prev_port == 1 && n_acks > 0) begin adr1 += 32'd4; m_adr[1] = adr1; end
        end
        release_port(0); release_port(1);
        chk("rr_first_port", first_port, 32'd0);
        chk("rr_cnt0", cnt0, 32'd50);
        chk("rr_cnt1", cnt1, 32'd50);

        // abort: port 0 drops CYC in ACCESS
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h20, 4'hF, 32'h12345678);
        @(negedge clk);
        @(posedge clk); #1;
        m_cyc[0] = 1'b0;
        @(negedge clk);
        chk("abort_we", sm.write_en, 32'd0);
        @(negedge clk);
        chk("abort_ack", s0.ack, 32'd0);
        @(posedge clk); #1;
        release_port(0);
        xfer(1, 1'b0, 32'h20, 4'hF, 32'd0, rd, lat);
        chk("abort_nowrite", rd, init_word(8));
        chk("abort_p1_lat", lat, 32'd2);

        // asynchronous reset during RESP
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h30, 4'hF, 32'd0);
        wait_ack(0, lat);
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_ack", s0.ack, 32'd0);
        chk("async_rst_re", sm.read_en, 32'd0);
        release_port(0);
        @(posedge clk); #1; rstn = 1'b1;
        xfer(0, 1'b0, 32'h30, 4'hF, 32'd0, rd, lat);
        chk("post_rst_lat", lat, 32'd2);
        chk("post_rst_data", rd, init_word(12));

        // fixed-priority instance: port 0 served last, still wins the tie
        xfer(2, 1'b0, 32'h40, 4'hF, 32'd0, rd, lat);
        chk("fp_solo_data", rd, init_word(16));
        dual(2, 2);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/wb_sram_2port_arbiter.md
Name: wb_sram_2port_arbiter

Overview:
- Shares one byte-enable generic SRAM between two Wishbone masters.
- Two wb_if.slave ports arbitrate onto a single generic_sram_byte_en_if.sram_client.
- Arbitration is round-robin or fixed-priority, with one registered transaction at a time.
- Sits between the interconnect's two requester legs (for example, CPU and DMA) and one on-chip SRAM macro with 1-cycle read latency.

Parameters:
- ADDRESS_WIDTH, 10, SRAM word-address width.
- DATA_WIDTH, 32, data width in bits; multiple of 8, at least 32; SEL width is DATA_WIDTH/8.
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins a tie.

Ports:
- clk  input  1  single clock; everything is rising-edge.
- rstn  input  1  reset, asynchronous, active-low.
- wb_s0  interface  wb_if.slave  requester port 0.
- wb_s1  interface  wb_if.slave  requester port 1.
- sram_m  interface  generic_sram_byte_en_if.sram_client  shared SRAM.

Behaviour:
- Definitions:
  - reqN = wb_sN.CYC & wb_sN.STB.
  - W = log2(DATA_WIDTH/8).
- Reset (rstn=0, asynchronous):
  - state=IDLE, grant=0, last=1.
  - Both ACK=0, sram read_en=0, write_en=0.
- ERR on both ports is tied 0.
- DAT_R on both ports = sram_m.read_data. It is only meaningful with ACK.
- Arbitration rule (pick), applied to the eligible request set:
  - One request only: that port wins.
  - Both requesting, FIXED_PRIORITY=1: port 0 wins.
  - Both requesting, FIXED_PRIORITY=0: the port != last wins.
- SRAM drive (combinational from the granted port, only in ACCESS):
  - addr = ADR[ADDRESS_WIDTH-1+W:W]
  - byte_en = SEL
  - write_data = DAT_W
  - write_en = reqG & WE
  - read_en = reqG & !WE
- Outside ACCESS, read_en and write_en are 0. addr, byte_en and write_data follow port `grant` and are don't-care.
- State IDLE:
  - If req0 or req1: grant <= pick(req0, req1); go to ACCESS.
  - Otherwise stay in IDLE.
- State ACCESS (exactly one cycle):
  - Drives the SRAM strobe.
  - reqG=1: go to RESP.
  - reqG=0 (master aborted): no strobe issued; go to IDLE; last unchanged.
- State RESP (exactly one cycle):
  - Asserts wb_sG.ACK = reqG. Read data is valid this cycle (SRAM 1-cycle latency).
  - last <= grant.
  - Next grant is evaluated with the granted port excluded, because its STB is still high this cycle.
  - Other port requesting: grant <= other; go to ACCESS (back-to-back, no IDLE bubble).
  - Otherwise: go to IDLE.
- Latency: STB sampled in IDLE, ACCESS on the next cycle, ACK two cycles after the IDLE sample.
  - Single-port throughput: 1 transfer per 3 cycles.
  - Alternating ports: 1 transfer per 2 cycles.
- The ACK pulse is 1 cycle wide and never goes to both ports in the same cycle.
- The SRAM sees at most one of read_en/write_en per cycle, never both.
- Abort during RESP (reqG=0):
  - No ACK is issued.
  - A write already performed stays performed.
  - last <= grant.
- A master holding STB across multiple beats gets one ACK per beat. Each beat re-arbitrates in IDLE, so under round-robin the other port may interleave.
- rstn asserted mid-transaction: state, ACK and SRAM strobes clear asynchronously; no partial ACK is produced.

Test Plan:
- Single write then read, port 0 only:
  - Stimulus: write ADR=0x0000_0010, SEL=4'hF, DAT_W=0xDEADBEEF; then read ADR=0x10.
  - Required: sram addr=4, write_en exactly 1 cycle, ACK 2 cycles after STB; read returns 0xDEADBEEF with ACK.
- Byte-enable merge:
  - Stimulus: port 1 writes 0x11223344 SEL=4'hF to word 5; then 0xAABBCCDD SEL=4'b0101 to word 5; then reads word 5.
  - Required: read returns 0x11BB33DD.
- Round-robin contention:
  - Stimulus: both ports continuously request reads of distinct words from reset.
  - Required: grants alternate 0,1,0,1; ACKs land on alternate cycles; 2-cycle spacing; neither port starves over 100 transfers.
- Fixed priority (FIXED_PRIORITY=1):
  - Stimulus: both ports request together from IDLE.
  - Required: port 0 granted first. Port 1 is served in the back-to-back slot after port 0's RESP; there it is the only eligible port because port 0 is excluded.
- Abort:
  - Stimulus: port 0 raises CYC/STB/WE, then drops CYC in the ACCESS cycle.
  - Required: no write_en pulse, no ACK; state returns to IDLE; a subsequent port 1 request is granted normally.
- Async reset mid-read:
  - Stimulus: assert rstn=0 during RESP.
  - Required: ACK and read_en fall immediately without waiting for clk; after release, first request completes with 2-cycle ACK latency.
